pq_arbiter: RTL and testbench
=============================

Name: pq_arbiter

Overview:
- Shares one priority-queue instance among N_REQ independent requesters.
- Performs round-robin arbitration over enqueue/dequeue requests and sequences each granted operation on the queue's enq/deq/busy handshake.
- Returns the dequeued key-value pair, or completion status, to the winning requester.
- Sits between the requester logic (auto-test FSMs, LFSR sources) and the pq client-side signals.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- KVW, 16, key-value width; key = [KVW-1:KVW/2], value = [KVW/2-1:0].
- TMO, 255, max cycles in WAIT before abort with error.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- req_enq  input  N_REQ  per-requester enqueue request (level, hold until ack).
- req_deq  input  N_REQ  per-requester dequeue request (level, hold until ack).
- req_kvi  input  N_REQ*KVW  per-requester enqueue data; slice i = [i*KVW +: KVW].
- ack  output  N_REQ  one-cycle completion pulse to the served requester.
- err  output  1  one-cycle pulse with ack when the served op timed out.
- rsp_kvo  output  KVW  dequeued data; valid in the ack cycle, held until the next dequeue ack.
- gnt_id  output  3  index of the current/last granted requester.
- pq_enq  output  1  enqueue strobe to the queue.
- pq_deq  output  1  dequeue strobe to the queue.
- pq_kvi  output  KVW  data to the queue.
- pq_kvo  input  KVW  queue head (combinational peek).
- pq_busy  input  1  queue operation in progress.
- pq_full  input  1  queue full.
- pq_empty  input  1  queue empty.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0, gnt_id=0.
  - ack=0, err=0, rsp_kvo=0, pq_enq=0, pq_deq=0, pq_kvi=0, timeout counter=0.
  - Reset mid-operation abandons the op; no ack is issued.
- Eligibility:
  - Requester i is eligible if (req_deq[i] && !pq_empty) or (req_enq[i] && !pq_full).
  - If both req_enq[i] and req_deq[i] are set, the dequeue is taken.
  - Ineligible requests stall without error.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If pq_busy=0 and any requester is eligible, grant the first eligible index at or after rr_ptr (wrapping N_REQ-1 -> 0).
  - On grant: latch gnt_id, op type, and req_kvi slice into pq_kvi, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Assert pq_enq or pq_deq, never both; pq_kvi stays stable.
  - For a dequeue, capture pq_kvo into an internal hold register this cycle (head before removal).
  - Next state: WAIT; clear the timeout counter.
- WAIT:
  - Strobes are low.
  - If pq_busy=0, go to DONE; the first WAIT cycle counts, so a zero-latency queue is legal.
  - Otherwise increment the counter. When counter==TMO, go to DONE with an error flag set.
- DONE (1 cycle):
  - ack[gnt_id]=1; err=error flag.
  - On a successful dequeue, rsp_kvo <= hold register.
  - rr_ptr <= (gnt_id+1) mod N_REQ; return to IDLE.
- Throughput and latency:
  - Minimum 4 cycles per op (IDLE grant -> ISSUE -> WAIT -> DONE).
  - Request-to-ack latency is 3 cycles plus the pq_busy duration when uncontended.
- Requester data:
  - req_kvi is sampled only at grant; later changes are ignored.
  - A request withdrawn before ack still completes; the ack is still pulsed.
- Full/empty: evaluated only at grant. Changes during WAIT do not affect the in-flight op.
- gnt_id, pq_kvi, rsp_kvo hold their values between ops.
- pq_enq/pq_deq are registered outputs and are never asserted outside ISSUE.

Test Plan:
- Reset, then req_enq[2]=1 with slice 2=16'hA55A, queue idle/not full -> pq_enq high exactly 1 cycle with pq_kvi=16'hA55A; pq_busy held 3 cycles -> ack[2] pulse at cycle 3+3; err=0.
- All four requesters request enq simultaneously, rr_ptr=0 -> grant order 0,1,2,3, each with exactly one ack; then req 1 and 3 -> order 1,3 after pointer wrap check.
- pq_empty=1, req_deq[0]=1 -> no pq_deq and no ack for 20 cycles; drop pq_empty with head 16'h0F21 -> pq_deq pulse, ack[0], rsp_kvo=16'h0F21.
- pq_full=1, req_enq[1]=1 and req_deq[3]=1 -> requester 3 is served first (dequeue), then requester 1 once full clears.
- TMO=8, pq_busy stuck high after ISSUE -> ack and err pulse together 8 WAIT cycles later; FSM returns to IDLE.
- rst asserted during WAIT -> all outputs 0 immediately (asynchronous), no ack; after release, a pending request is re-granted from rr_ptr=0.

Source files
------------

// File: rtl/pq_arbiter.sv
// Round-robin arbiter sharing one priority queue among N_REQ requesters; >=4 cycles per op,
// ack 3 cycles + pq_busy time after grant. Ineligible requests (full/empty) stall, WAIT aborts with err after TMO.
module pq_arbiter #(
   parameter int N_REQ = 4,
   parameter int KVW   = 16,
   parameter int TMO   = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_enq,
   input  logic [N_REQ-1:0]     req_deq,
   input  logic [N_REQ*KVW-1:0] req_kvi,
   output logic [N_REQ-1:0]     ack,
   output logic                 err,
   output logic [KVW-1:0]       rsp_kvo,
   output logic [2:0]           gnt_id,
   output logic                 pq_enq,
   output logic                 pq_deq,
   output logic [KVW-1:0]       pq_kvi,
   input  logic [KVW-1:0]       pq_kvo,
   input  logic                 pq_busy,
   input  logic                 pq_full,
   input  logic                 pq_empty
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam int CW = $clog2(TMO + 1);

   logic [1:0]     state_q, state_d;
   logic [2:0]     rr_ptr_q, rr_ptr_d;
   logic [2:0]     gnt_id_q, gnt_id_d;
   logic           op_deq_q, op_deq_d;
   logic [KVW-1:0] kvi_q, kvi_d;
   logic [KVW-1:0] hold_q, hold_d;
   logic [KVW-1:0] rsp_q, rsp_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           errf_q, errf_d;
   logic           enq_q, enq_d;
   logic           deq_q, deq_d;

   logic [N_REQ-1:0]   elig;
   logic [N_REQ-1:0]   rot;
   logic               found;
   logic [3:0]         sum;
   logic [2:0]         sel;
   logic [7:0]         deq_pad;
   logic [8*KVW-1:0]   kvi_pad;

   // Rotate eligibility so bit 0 is rr_ptr; the lowest set bit is the winner.
   always_comb begin
      elig    = (req_deq & {N_REQ{~pq_empty}}) | (req_enq & {N_REQ{~pq_full}});
      rot     = N_REQ'({elig, elig} >> rr_ptr_q);
      deq_pad = 8'(req_deq);
      kvi_pad = (8*KVW)'(req_kvi);
      found   = 1'b0;
      sum     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr_q} + 4'(k);
         end
      end
      if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
      sel = sum[2:0];
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_id_d = gnt_id_q;
      op_deq_d = op_deq_q;
      kvi_d    = kvi_q;
      hold_d   = hold_q;
      rsp_d    = rsp_q;
      cnt_d    = cnt_q;
      errf_d   = errf_q;
      enq_d    = 1'b0;
      deq_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!pq_busy && found) begin
               state_d  = ISSUE;
               gnt_id_d = sel;
               // Dequeue wins when a requester asks for both.
               op_deq_d = deq_pad[sel] & ~pq_empty;
               kvi_d    = KVW'(kvi_pad >> (sel * KVW));
               enq_d    = ~(deq_pad[sel] & ~pq_empty);
               deq_d    = deq_pad[sel] & ~pq_empty;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = '0;
            errf_d  = 1'b0;
            if (op_deq_q) hold_d = pq_kvo;
         end
         WAIT: begin
            if (!pq_busy) begin
               state_d = DONE;
               if (op_deq_q) rsp_d = hold_q;
            end else if (cnt_q == CW'(TMO - 1)) begin
               state_d = DONE;
               errf_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d  = IDLE;
            rr_ptr_d = (gnt_id_q == 3'(N_REQ - 1)) ? 3'd0 : gnt_id_q + 3'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gnt_id_q <= '0;
         op_deq_q <= 1'b0;
         kvi_q    <= '0;
         hold_q   <= '0;
         rsp_q    <= '0;
         cnt_q    <= '0;
         errf_q   <= 1'b0;
         enq_q    <= 1'b0;
         deq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_id_q <= gnt_id_d;
         op_deq_q <= op_deq_d;
         kvi_q    <= kvi_d;
         hold_q   <= hold_d;
         rsp_q    <= rsp_d;
         cnt_q    <= cnt_d;
         errf_q   <= errf_d;
         enq_q    <= enq_d;
         deq_q    <= deq_d;
      end
   end

   assign ack     = (state_q == DONE) ? (N_REQ'(1) << gnt_id_q) : '0;
   assign err     = (state_q == DONE) & errf_q;
   assign rsp_kvo = rsp_q;
   assign gnt_id  = gnt_id_q;
   assign pq_enq  = enq_q;
   assign pq_deq  = deq_q;
   assign pq_kvi  = kvi_q;

endmodule

// File: tb/tb_pq_arbiter.sv
// Scoreboard bench for pq_arbiter: directed requests against a small pq_busy model.
module tb_pq_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_enq, req_deq;
   logic [63:0] req_kvi;
   logic [3:0]  ack;
   logic        err;
   logic [15:0] rsp_kvo;
   logic [2:0]  gnt_id;
   logic        pq_enq, pq_deq;
   logic [15:0] pq_kvi, pq_kvo;
   logic        pq_busy, pq_full, pq_empty;

   pq_arbiter #(.N_REQ(4), .KVW(16), .TMO(8)) dut (
      .clk(clk), .rst(rst),
      .req_enq(req_enq), .req_deq(req_deq), .req_kvi(req_kvi),
      .ack(ack), .err(err), .rsp_kvo(rsp_kvo), .gnt_id(gnt_id),
      .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
      .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty)
   );

   typedef struct packed { logic enq; logic deq; logic chk_kvi; logic [15:0] kvi; } stb_t;
   typedef struct packed { logic [3:0] ack; logic err; logic chk_rsp; logic [15:0] rsp; } ack_t;

   stb_t stb_q[$];
   ack_t ack_q[$];
   int   tests = 0;
   int   fails = 0;
   int   n_stb = 0;
   int   n_ack = 0;
   int   busy_len = 3;
   int   rem = 0;
   int   cyc;
   int   s0, a0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no completion, required summary");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_stb(input logic e, input logic d, input logic ck, input logic [15:0] kv);
      stb_q.push_back('{enq: e, deq: d, chk_kvi: ck, kvi: kv});
   endtask

   task automatic push_ack(input logic [3:0] a, input logic e, input logic ck, input logic [15:0] r);
      ack_q.push_back('{ack: a, err: e, chk_rsp: ck, rsp: r});
   endtask

   task automatic wait_ack(input int max, output int c);
      c = 0;
      @(negedge clk);
      while (ack == 4'd0 && c < max) begin
         @(negedge clk);
         c++;
      end
      if (ack == 4'd0) begin
         tests++;
         fails++;
         $display("FAIL wait_ack: no ack within %0d cycles", max);
      end
   endtask

   task automatic wait_drain(input int max);
      int c;
      c = 0;
      while ((stb_q.size() != 0 || ack_q.size() != 0) && c < max) begin
         @(negedge clk);
         c++;
      end
      tests++;
      if (stb_q.size() != 0 || ack_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d strobes and %0d acks still pending, required 0 and 0",
                  stb_q.size(), ack_q.size());
         stb_q.delete();
         ack_q.delete();
      end
      step();
   endtask

   // Queue model plus requesters that drop their request on ack.
   initial begin
      logic       stb;
      logic [3:0] a;
      pq_busy = 1'b0;
      forever begin
         @(negedge clk);
         stb = pq_enq | pq_deq;
         a   = ack;
         @(posedge clk);
         #1;
         req_enq = req_enq & ~a;
         req_deq = req_deq & ~a;
         if (stb) rem = busy_len;
         if (rem > 0) begin
            pq_busy = 1'b1;
            rem--;
         end else begin
            pq_busy = 1'b0;
         end
      end
   end

   // Monitor: pops expected strobes and acks as the DUT presents them.
   initial begin
      stb_t es;
      ack_t ea;
      forever begin
         @(negedge clk);
         if (pq_enq || pq_deq) begin
            n_stb++;
            if (stb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_strobe: enq=%0b deq=%0b, required none", pq_enq, pq_deq);
            end else begin
               es = stb_q.pop_front();
               chk("strobe_enq", pq_enq, es.enq);
               chk("strobe_deq", pq_deq, es.deq);
               if (es.chk_kvi) chk("strobe_kvi", pq_kvi, es.kvi);
            end
         end
         if (ack != 4'd0) begin
            n_ack++;
            if (ack_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ack: ack=%0b, required none", ack);
            end else begin
               ea = ack_q.pop_front();
               chk("ack_vec", ack, ea.ack);
               chk("ack_err", err, ea.err);
               if (ea.chk_rsp) chk("ack_rsp_kvo", rsp_kvo, ea.rsp);
            end
         end else if (err) begin
            tests++;
            fails++;
            $display("FAIL err_without_ack: err=1, required 0");
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      rem = 0;
      req_enq = '0;
      req_deq = '0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      rst = 1'b0;
      req_enq = '0;
      req_deq = '0;
      req_kvi = '0;
      pq_kvo = '0;
      pq_full = 1'b0;
      pq_empty = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_rsp_kvo", rsp_kvo, 0);
      chk("rst_pq_enq", pq_enq, 0);
      chk("rst_pq_deq", pq_deq, 0);
      chk("rst_pq_kvi", pq_kvi, 0);
      chk("rst_gnt_id", gnt_id, 0);
      step();
      rst = 1'b1;
      step();

      // Single enqueue, busy for 3 cycles
      busy_len = 3;
      req_kvi[32 +: 16] = 16'hA55A;
      push_stb(1'b1, 1'b0, 1'b1, 16'hA55A);
      push_ack(4'b0100, 1'b0, 1'b0, 16'h0);
      s0 = n_stb;
      req_enq[2] = 1'b1;
      wait_ack(40, cyc);
      chk("t1_latency", cyc, 6);
      chk("t1_gnt_id", gnt_id, 2);
      step();
      chk("t1_strobe_cycles", n_stb - s0, 1);

      // All four contend from rr_ptr=0, then 1 and 3 after the wrap
      do_reset();
      busy_len = 1;
      req_kvi = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      for (int i = 0; i < 4; i++) begin
         push_stb(1'b1, 1'b0, 1'b1, 16'h1000 + 16'(i));
         push_ack(4'(1 << i), 1'b0, 1'b0, 16'h0);
      end
      req_enq = 4'hF;
      wait_drain(200);
      chk("t2_last_gnt", gnt_id, 3);
      push_stb(1'b1, 1'b0, 1'b1, 16'h1001);
      push_ack(4'b0010, 1'b0, 1'b0, 16'h0);
      push_stb(1'b1, 1'b0, 1'b1, 16'h1003);
      push_ack(4'b1000, 1'b0, 1'b0, 16'h0);
      req_enq = 4'b1010;
      wait_drain(100);

      // Dequeue stalls while empty
      req_kvi = '0;
      pq_empty = 1'b1;
      pq_kvo = 16'h0F21;
      req_deq[0] = 1'b1;
      s0 = n_stb;
      a0 = n_ack;
      repeat (20) step();
      chk("t3_stall_strobes", n_stb - s0, 0);
      chk("t3_stall_acks", n_ack - a0, 0);
      push_stb(1'b0, 1'b1, 1'b0, 16'h0);
      push_ack(4'b0001, 1'b0, 1'b1, 16'h0F21);
      pq_empty = 1'b0;
      wait_drain(50);
      pq_kvo = 16'hFFFF;
      repeat (3) step();
      chk("t3_rsp_hold", rsp_kvo, 16'h0F21);

      // Full queue: dequeue by 3 proceeds, enqueue by 1 waits
      pq_full = 1'b1;
      pq_kvo = 16'h3C3C;
      req_kvi[16 +: 16] = 16'hB001;
      push_stb(1'b0, 1'b1, 1'b0, 16'h0);
      push_ack(4'b1000, 1'b0, 1'b1, 16'h3C3C);
      push_stb(1'b1, 1'b0, 1'b1, 16'hB001);
      push_ack(4'b0010, 1'b0, 1'b0, 16'h0);
      req_enq[1] = 1'b1;
      req_deq[3] = 1'b1;
      wait_ack(40, cyc);
      chk("t4_first_gnt", gnt_id, 3);
      repeat (4) step();
      chk("t4_full_stall", req_enq[1], 1);
      pq_full = 1'b0;
      wait_drain(50);
      chk("t4_rsp_after_enq", rsp_kvo, 16'h3C3C);

      // Timeout with pq_busy stuck high
      busy_len = 1000;
      req_kvi[0 +: 16] = 16'h7777;
      push_stb(1'b1, 1'b0, 1'b1, 16'h7777);
      push_ack(4'b0001, 1'b1, 1'b0, 16'h0);
      req_enq[0] = 1'b1;
      wait_ack(40, cyc);
      chk("t5_tmo_latency", cyc, 10);
      chk("t5_err", err, 1);
      step();
      rem = 0;
      busy_len = 0;
      repeat (3) step();
      req_kvi[32 +: 16] = 16'h2222;
      push_stb(1'b1, 1'b0, 1'b1, 16'h2222);
      push_ack(4'b0100, 1'b0, 1'b0, 16'h0);
      req_enq[2] = 1'b1;
      wait_ack(40, cyc);
      chk("t5_zero_busy_latency", cyc, 3);
      step();

      // Reset during WAIT abandons the op; re-grant starts from rr_ptr=0
      busy_len = 5;
      req_kvi[16 +: 16] = 16'h1111;
      req_kvi[48 +: 16] = 16'h3333;
      push_stb(1'b1, 1'b0, 1'b1, 16'h3333);
      req_enq = 4'b1010;
      repeat (3) step();
      chk("t6_gnt_before_rst", gnt_id, 3);
      rst = 1'b0;
      rem = 0;
      #1;
      chk("t6_rst_ack", ack, 0);
      chk("t6_rst_err", err, 0);
      chk("t6_rst_pq_enq", pq_enq, 0);
      chk("t6_rst_pq_deq", pq_deq, 0);
      chk("t6_rst_pq_kvi", pq_kvi, 0);
      chk("t6_rst_rsp_kvo", rsp_kvo, 0);
      chk("t6_rst_gnt_id", gnt_id, 0);
      step();
      step();
      busy_len = 1;
      push_stb(1'b1, 1'b0, 1'b1, 16'h1111);
      push_ack(4'b0010, 1'b0, 1'b0, 16'h0);
      push_stb(1'b1, 1'b0, 1'b1, 16'h3333);
      push_ack(4'b1000, 1'b0, 1'b0, 16'h0);
      rst = 1'b1;
      wait_drain(100);
      repeat (3) step();
      chk("sb_leftover", stb_q.size() + ack_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
